// File: rtl/i2c_target.sv
// i2c_target: I2C responder with filtered inputs, 7-bit address match, write stream out and read byte requests
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WRITE, W_ACK, W_NACK, R_WAIT, READ, R_ACK, IGNORE} state_t;
  state_t state, n_state;
  logic [1:0] s1, s2, f, fd;
  logic [1:0][3:0] fc;
  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
  logic [3:0] cnt, n_cnt;
  logic [7:0] sh, n_sh, n_rx_data;
  logic rw, n_rw, ok, n_ok, first, n_first, cap;
  logic n_oe, n_rx_valid, n_rx_first, n_tx_req, n_busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      f <= '1;
      fd <= '1;
      fc <= '0;
    end else begin
      s1 <= {sda_i, scl_i};
      s2 <= s1;
      fd <= f;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == f[i]) fc[i] <= '0;
        else if (fc[i] == 4'(FILTER_LEN - 1)) begin
          f[i] <= s2[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 4'd1;
      end
    end
  end
  assign scl_f = f[0];
  assign sda_f = f[1];
  assign scl_rise = scl_f & ~fd[0];
  assign scl_fall = ~scl_f & fd[0];
  assign start = fd[1] & ~sda_f & scl_f & fd[0];
  assign stop = ~fd[1] & sda_f & scl_f & fd[0];
  always_comb begin
    n_state = state;
    n_cnt = cnt;
    n_sh = cap ? tx_data : sh;
    n_oe = sda_oe;
    n_rx_data = rx_data;
    n_rx_first = rx_first;
    n_busy = busy;
    n_first = first;
    n_ok = ok;
    n_rw = rw;
    n_rx_valid = 1'b0;
    n_tx_req = 1'b0;
    if (start) begin
      n_state = ADDR;
      n_cnt = '0;
      n_oe = 1'b0;
      n_busy = 1'b0;
    end else if (stop) begin
      n_state = IDLE;
      n_oe = 1'b0;
      n_busy = 1'b0;
    end else begin
      case (state)
        ADDR:
          if (scl_rise) begin
            n_sh = {sh[6:0], sda_f};
            n_cnt = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            n_cnt = '0;
            if (sh[7:1] == TARGET_ADDR && TARGET_ADDR != 7'h00) begin
              n_state = ADDR_ACK;
              n_oe = 1'b1;
              n_busy = 1'b1;
              n_first = 1'b1;
              n_rw = sh[0];
            end else n_state = IGNORE;
          end
        ADDR_ACK:
          if (scl_rise && rw) begin
            n_tx_req = 1'b1;
            n_state = R_WAIT;
          end else if (scl_fall) begin
            n_oe = 1'b0;
            n_state = WRITE;
          end
        WRITE:
          if (scl_rise) begin
            n_sh = {sh[6:0], sda_f};
            n_cnt = cnt + 4'd1;
            if (cnt == 4'd7) begin
              n_ok = rx_ready;
              n_rx_valid = rx_ready;
              if (rx_ready) begin
                n_rx_data = {sh[6:0], sda_f};
                n_rx_first = first;
                n_first = 1'b0;
              end
            end
          end else if (scl_fall && cnt == 4'd8) begin
            n_cnt = '0;
            n_oe = ok;
            n_state = ok ? W_ACK : W_NACK;
          end
        W_ACK:
          if (scl_fall) begin
            n_oe = 1'b0;
            n_state = WRITE;
          end
        W_NACK:
          if (scl_fall) begin
            n_state = IGNORE;
            n_busy = 1'b0;
          end
        R_WAIT:
          if (scl_fall) begin
            n_oe = ~sh[7];
            n_cnt = '0;
            n_state = READ;
          end
        READ:
          if (scl_fall) begin
            if (cnt == 4'd7) begin
              n_oe = 1'b0;
              n_state = R_ACK;
            end else begin
              n_sh = {sh[6:0], 1'b0};
              n_oe = ~sh[6];
              n_cnt = cnt + 4'd1;
            end
          end
        R_ACK:
          if (scl_rise) begin
            if (sda_f) begin
              n_state = IGNORE;
              n_busy = 1'b0;
            end else begin
              n_tx_req = 1'b1;
              n_state = R_WAIT;
            end
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      sda_oe <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_first <= 1'b0;
      tx_req <= 1'b0;
      busy <= 1'b0;
      first <= 1'b0;
      ok <= 1'b0;
      rw <= 1'b0;
      cap <= 1'b0;
    end else begin
      state <= n_state;
      cnt <= n_cnt;
      sh <= n_sh;
      sda_oe <= n_oe;
      rx_valid <= n_rx_valid;
      rx_data <= n_rx_data;
      rx_first <= n_rx_first;
      tx_req <= n_tx_req;
      busy <= n_busy;
      first <= n_first;
      ok <= n_ok;
      rw <= n_rw;
      cap <= tx_req;
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: randomized I2C initiator bench with a transaction-level expectation model
module tb_i2c_target;
  localparam int Q = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic sda_oe, rx_valid, rx_first, tx_req, busy, sda_ln;
  logic [7:0] rx_data;
  int errors = 0;
  int checks = 0;
  logic [8:0] rx_q[$];
  logic [7:0] tx_q[$];
  int n_req = 0;
  int oe_viol = 0;
  bit oe_seen = 0;
  bit oe_p = 0;
  logic [7:0] wd[4];
  bit wr[4];
  logic [7:0] rd[4];
  assign sda_ln = sda_m & ~sda_oe;
  i2c_target #(.TARGET_ADDR(7'h42), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_ln), .sda_oe(sda_oe),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_first(rx_first), .rx_ready(rx_ready),
    .tx_req(tx_req), .tx_data(tx_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back({rx_first, rx_data});
    if (tx_req) begin
      n_req++;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      else tx_data = 8'hFF;
    end
    if (sda_oe) oe_seen = 1;
    if (sda_oe && !oe_p && scl) oe_viol++;
    oe_p = sda_oe;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr();
    rx_q.delete();
    tx_q.delete();
    n_req = 0;
    oe_seen = 0;
  endtask
  task automatic bus_start();
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    sda_m = 1'b0;
    tick(2 * Q);
    scl = 1'b0;
    tick(Q);
  endtask
  task automatic bus_stop();
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    sda_m = 1'b1;
    tick(2 * Q);
  endtask
  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    r = sda_ln;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(nack, r);
  endtask
  task automatic run_write_case(input logic [7:0] a, input int n);
    logic ack;
    logic [8:0] exp_q[$];
    bit m_ok;
    clr();
    m_ok = (a[7:1] == 7'h42);
    bus_start();
    send_byte(a, ack);
    checks++;
    if (ack !== m_ok) begin errors++; $display("FAIL addr_ack a=%h: got %b want %b", a, ack, m_ok); end
    for (int i = 0; i < n; i++) begin
      rx_ready = wr[i];
      send_byte(wd[i], ack);
      checks++;
      if (ack !== (m_ok & wr[i])) begin errors++; $display("FAIL data_ack a=%h byte%0d: got %b want %b", a, i, ack, m_ok & wr[i]); end
      if (m_ok && wr[i]) exp_q.push_back({1'(i == 0), wd[i]});
      else m_ok = 0;
    end
    rx_ready = 1'b1;
    checks++;
    if (busy !== m_ok) begin errors++; $display("FAIL busy_mid a=%h: got %b want %b", a, busy, m_ok); end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_stop a=%h: got %b want 0", a, busy); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rx_count a=%h: got %0d want %0d", a, rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rx_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (oe_seen !== (a[7:1] == 7'h42)) begin errors++; $display("FAIL oe_seen a=%h: got %b want %b", a, oe_seen, a[7:1] == 7'h42); end
  endtask
  task automatic run_read_case(input logic [7:0] a, input int n);
    logic ack;
    logic [7:0] got;
    bit m;
    clr();
    for (int i = 0; i < n; i++) tx_q.push_back(rd[i]);
    m = (a[7:1] == 7'h42) && a[0];
    bus_start();
    send_byte(a, ack);
    checks++;
    if (ack !== m) begin errors++; $display("FAIL rd_addr_ack a=%h: got %b want %b", a, ack, m); end
    if (m) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, got);
        checks++;
        if (got !== rd[i]) begin errors++; $display("FAIL rd_byte%0d: got %h want %h", i, got, rd[i]); end
      end
    end
    checks++;
    if (n_req !== (m ? n : 0)) begin errors++; $display("FAIL tx_req_count: got %0d want %0d", n_req, m ? n : 0); end
    checks++;
    if ({sda_oe, busy} !== 2'b00) begin errors++; $display("FAIL rd_after_nack: got oe=%b busy=%b want 0 0", sda_oe, busy); end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    checks++;
    if (rx_first !== 1'b0) begin errors++; $display("FAIL rst_rx_first: got %b want 0", rx_first); end
    checks++;
    if (tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick(30);
  endtask
  task automatic test_write();
    logic [7:0] addrs[4];
    wd[0] = 8'hA5; wd[1] = 8'h3C; wr[0] = 1; wr[1] = 1;
    run_write_case(8'h84, 2);
    addrs = '{8'h84, 8'h84, 8'h00, 8'h00};
    addrs[3] = 8'($urandom) & 8'hFE;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        wd[i] = 8'($urandom);
        wr[i] = ($urandom_range(0, 3) != 0);
      end
      run_write_case(addrs[k], $urandom_range(1, 3));
    end
  endtask
  task automatic test_wrong_addr();
    for (int i = 0; i < 2; i++) begin
      wd[i] = 8'($urandom);
      wr[i] = 1;
    end
    run_write_case(8'h86, 2);
  endtask
  task automatic test_ready_drop();
    wd[0] = 8'($urandom); wd[1] = 8'($urandom); wr[0] = 1; wr[1] = 0;
    run_write_case(8'h84, 2);
    wd[0] = 8'($urandom); wr[0] = 1;
    run_write_case(8'h84, 1);
  endtask
  task automatic test_read();
    rd[0] = 8'h5A; rd[1] = 8'hC3;
    run_read_case(8'h85, 2);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
      run_read_case(8'h85, $urandom_range(1, 3));
    end
    rd[0] = 8'($urandom);
    run_read_case(8'h87, 1);
  endtask
  task automatic test_rstart();
    logic ack, r;
    logic [7:0] part, b, got;
    clr();
    part = 8'($urandom);
    b = 8'($urandom);
    bus_start();
    send_byte(8'h84, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL rs_w_ack: got %b want 1", ack); end
    for (int i = 7; i > 3; i--) bus_bit(part[i], r);
    tx_q.push_back(b);
    bus_start();
    send_byte(8'h85, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL rs_r_ack: got %b want 1", ack); end
    recv_byte(1'b1, got);
    checks++;
    if (got !== b) begin errors++; $display("FAIL rs_read: got %h want %h", got, b); end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL rs_no_rx: got %0d want 0", rx_q.size()); end
    checks++;
    if (n_req !== 1) begin errors++; $display("FAIL rs_tx_req: got %0d want 1", n_req); end
    bus_stop();
  endtask
  task automatic test_reset_mid();
    logic ack, r;
    logic [7:0] b;
    clr();
    b = 8'($urandom) & 8'hF7;
    tx_q.push_back(b);
    bus_start();
    send_byte(8'h85, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL rm_addr_ack: got %b want 1", ack); end
    for (int i = 7; i > 3; i--) begin
      bus_bit(1'b1, r);
      checks++;
      if (r !== b[i]) begin errors++; $display("FAIL rm_bit%0d: got %b want %b", i, r, b[i]); end
    end
    sda_m = 1'b1;
    tick(Q);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL rm_oe_pre: got %b want 1", sda_oe); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rm_oe_rst: got %b want 0", sda_oe); end
    rst = 1'b0;
    oe_seen = 0;
    scl = 1'b1;
    tick(2 * Q);
    scl = 1'b0;
    tick(Q);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
    send_byte(8'h84, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rm_no_start: got %b want 0", ack); end
    checks++;
    if ({oe_seen, busy} !== 2'b00) begin errors++; $display("FAIL rm_quiet: got oe_seen=%b busy=%b want 0 0", oe_seen, busy); end
    bus_stop();
    wd[0] = 8'($urandom); wr[0] = 1;
    run_write_case(8'h84, 1);
  endtask
  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_ready_drop();
    test_rstart();
    test_reset_mid();
    checks++;
    if (oe_viol !== 0) begin errors++; $display("FAIL oe_scl_high: got %0d want 0", oe_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
